sdc_block_addr_gen: RTL and testbench
=====================================

Name: sdc_block_addr_gen

Overview:
Parametrised address generator for the FPGA-to-SDC write path. It counts data-byte strobes within an SD block and advances the card address by one block step when a block completes. It supports byte-addressed (SDSC) and block-addressed (SDHC/SDXC) cards, a loadable start address, an end-address limit with wrap or stop, and a completed-block count. It sits between the byte-streaming write FSM and the CMD24/CMD25 command builder.

Parameters:
ADDR_W, 32, width of card address.
BLOCK_BYTES, 512, bytes per block; must be a power of 2 and at least 2.
BYTE_W, $clog2(BLOCK_BYTES), width of the byte index.
CNT_W, 16, width of the completed-block counter.
ADDR_MODE, 1, 0 = byte addressing (step = BLOCK_BYTES), 1 = block addressing (step = 1).
START_ADDR, 0, address after reset and the target of a wrap.
END_ADDR, {ADDR_W{1'b1}}, last legal block address.
WRAP_EN, 0, 1 = wrap to START_ADDR after END_ADDR, 0 = stop and flag full.

Ports:
clk  in  1  system clock; all logic on the rising edge.
resetCounter  in  1  synchronous, active-high reset.
loadAddr  in  1  load loadValue into addr; clears the byte index.
loadValue  in  ADDR_W  address to load.
nextByte  in  1  one data byte accepted this cycle.
addr  out  ADDR_W  current block address, registered.
byteIdx  out  BYTE_W  index of the next byte within the block.
blockCount  out  CNT_W  completed blocks since reset or load; saturates.
blockDone  out  1  one-cycle pulse when a block completes.
wrapped  out  1  one-cycle pulse when addr wraps to START_ADDR.
full  out  1  sticky; END_ADDR block completed and WRAP_EN=0.
errOverflow  out  1  sticky; a nextByte strobe was dropped while full.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on resetCounter.
- Reset (resetCounter=1 at the edge): addr=START_ADDR, byteIdx=0, blockCount=0, blockDone=0, wrapped=0, full=0, errOverflow=0. Reset beats every other input, including in the middle of a block.
- Priority order: resetCounter > loadAddr > nextByte.
- loadAddr=1: addr<=loadValue, byteIdx<=0, blockCount<=0, full<=0, errOverflow<=0. A simultaneous nextByte is discarded and is not counted.
- nextByte=1, full=0, byteIdx<BLOCK_BYTES-1: byteIdx<=byteIdx+1; addr is unchanged.
- nextByte=1, full=0, byteIdx=BLOCK_BYTES-1 (terminal byte):
  - byteIdx<=0.
  - blockCount<=blockCount+1, saturating at all ones.
  - blockDone=1 for exactly the next cycle.
  - If addr!=END_ADDR: addr<=addr+STEP, computed modulo 2^ADDR_W.
  - If addr=END_ADDR and WRAP_EN=1: addr<=START_ADDR and wrapped=1 for one cycle.
  - If addr=END_ADDR and WRAP_EN=0: addr holds and full<=1.
- Latency: the updated addr and the blockDone pulse appear together, one cycle after the terminal-byte strobe.
- The address increment is a single full-width add with carry in the same cycle. Split carry counters and a registered carry are prohibited, so there is no stale-carry cycle at 16-bit boundaries (e.g. 0x0000_FFFF -> 0x0001_0000).
- full=1: nextByte is ignored (byteIdx, addr and blockCount hold) and errOverflow<=1. Only reset or loadAddr clears full and errOverflow.
- With no strobe, all state holds, and blockDone and wrapped are 0.
- Byte mode with a loadValue not aligned to BLOCK_BYTES: the address is used as given; alignment is the caller's responsibility.
- Elaboration checks: BLOCK_BYTES is a power of 2, and END_ADDR>=START_ADDR.

Decomposition:
- Shared package sdc_pkg:
  - SD_BLOCK_BYTES=512
  - ADDR_MODE_BYTE=0, ADDR_MODE_BLOCK=1
  - a function returning the address step for (ADDR_MODE, BLOCK_BYTES)
- One natural sub-module, sdc_mod_counter: a modulo-N counter with enable, synchronous clear and a terminal-count output. It implements byteIdx; the parent owns addr, blockCount and the flags.

Test Plan:
1. Reset, then 512 nextByte strobes (ADDR_MODE=1, START_ADDR=0) -> byteIdx 0..511..0, addr=1 and blockDone=1 exactly one cycle after strobe 512, blockCount=1.
2. ADDR_MODE=0, loadValue=0x0000_FE00, then 512 strobes -> addr=0x0001_0000 with no intermediate wrong value, blockDone=1 once.
3. END_ADDR=3, WRAP_EN=1, START_ADDR=0, 4 full blocks -> addr sequence 1,2,3,0, wrapped=1 on the fourth block only, blockCount=4.
4. END_ADDR=1, WRAP_EN=0, 2 full blocks, then 5 more strobes -> full=1 with addr=1, byteIdx stays 0, errOverflow=1, blockCount=2; loadAddr with value 0x10 -> full=0, errOverflow=0, addr=0x10.
5. loadAddr and nextByte in the same cycle at byteIdx=511 -> addr=loadValue, byteIdx=0, no blockDone, blockCount=0.
6. resetCounter asserted at byteIdx=200 together with nextByte -> next cycle addr=START_ADDR, byteIdx=0, all flags 0.

Source files
------------

// File: rtl/sdc_pkg.sv
// Shared SD-card constants and the address-step helper used by the write-path address generator.
package sdc_pkg;

    localparam int unsigned SD_BLOCK_BYTES  = 32'd512;
    localparam int unsigned ADDR_MODE_BYTE  = 32'd0;
    localparam int unsigned ADDR_MODE_BLOCK = 32'd1;

    // SDSC cards advance by a block's worth of bytes, SDHC/SDXC by one block.
    function automatic int unsigned addr_step(input int unsigned addr_mode,
                                              input int unsigned block_bytes);
        int unsigned step_v;
        case (addr_mode)
            ADDR_MODE_BYTE:  step_v = block_bytes;
            ADDR_MODE_BLOCK: step_v = 32'd1;
            default:         step_v = 32'd1;
        endcase
        return step_v;
    endfunction

endpackage

// File: rtl/sdc_mod_counter.sv
// Modulo-N counter with enable, synchronous clear and a terminal-count flag.
module sdc_mod_counter #(
    parameter int unsigned N = 512,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 32'd1);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    // Next count: roll back to zero after the terminal value.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_r == LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + W'(1'b1);
        end
    end

    // Count register; reset beats clear beats enable.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_nxt_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == LAST);

endmodule

// File: rtl/sdc_block_addr_gen.sv
// SD write-path address generator: counts byte strobes per block and steps the card
// address on block completion, with wrap-or-stop at END_ADDR and a saturating block count.
module sdc_block_addr_gen
    import sdc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       BLOCK_BYTES = SD_BLOCK_BYTES,
    parameter int unsigned       BYTE_W      = $clog2(BLOCK_BYTES),
    parameter int unsigned       CNT_W       = 16,
    parameter int unsigned       ADDR_MODE   = ADDR_MODE_BLOCK,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0,
    parameter logic [ADDR_W-1:0] END_ADDR    = {ADDR_W{1'b1}},
    parameter int unsigned       WRAP_EN     = 0
) (
    input  logic              clk,
    input  logic              resetCounter,
    input  logic              loadAddr,
    input  logic [ADDR_W-1:0] loadValue,
    input  logic              nextByte,
    output logic [ADDR_W-1:0] addr,
    output logic [BYTE_W-1:0] byteIdx,
    output logic [CNT_W-1:0]  blockCount,
    output logic              blockDone,
    output logic              wrapped,
    output logic              full,
    output logic              errOverflow
);

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(addr_step(ADDR_MODE, BLOCK_BYTES));
    localparam logic              WRAP_BIT = (WRAP_EN != 32'd0);

    if ((BLOCK_BYTES < 32'd2) || ((BLOCK_BYTES & (BLOCK_BYTES - 32'd1)) != 32'd0)) begin : g_bad_block
        $error("sdc_block_addr_gen: BLOCK_BYTES must be a power of 2 and at least 2");
    end
    if (END_ADDR < START_ADDR) begin : g_bad_range
        $error("sdc_block_addr_gen: END_ADDR must not be below START_ADDR");
    end

    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              done_r;
    logic              wrapped_r;
    logic              full_r;
    logic              err_r;

    logic [BYTE_W-1:0] byte_idx_s;
    logic              byte_tc_s;
    logic              byte_en_s;
    logic              term_s;
    logic              at_end_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [CNT_W-1:0]  cnt_sat_s;

    // A strobe alongside a load is discarded; strobes while full are dropped.
    assign byte_en_s = nextByte & ~full_r & ~loadAddr;
    assign term_s    = byte_en_s & byte_tc_s;
    assign at_end_s  = (addr_r == END_ADDR);

    sdc_mod_counter #(
        .N (BLOCK_BYTES),
        .W (BYTE_W)
    ) u_byte_cnt (
        .clk  (clk),
        .srst (resetCounter),
        .clr  (loadAddr),
        .en   (byte_en_s),
        .cnt  (byte_idx_s),
        .tc   (byte_tc_s)
    );

    // Next block address: single full-width add so carries land in the same cycle.
    always_comb begin
        addr_nxt_s = addr_r;
        if (at_end_s) begin
            if (WRAP_BIT) begin
                addr_nxt_s = START_ADDR;
            end else begin
                addr_nxt_s = addr_r;
            end
        end else begin
            addr_nxt_s = addr_r + STEP;
        end
    end

    // Saturating completed-block count.
    always_comb begin
        cnt_sat_s = cnt_r;
        if (&cnt_r) begin
            cnt_sat_s = cnt_r;
        end else begin
            cnt_sat_s = cnt_r + CNT_W'(1'b1);
        end
    end

    // Address, count and flag registers; reset beats load beats strobe.
    always_ff @(posedge clk) begin
        if (resetCounter) begin
            addr_r    <= START_ADDR;
            cnt_r     <= '0;
            done_r    <= 1'b0;
            wrapped_r <= 1'b0;
            full_r    <= 1'b0;
            err_r     <= 1'b0;
        end else if (loadAddr) begin
            addr_r    <= loadValue;
            cnt_r     <= '0;
            done_r    <= 1'b0;
            wrapped_r <= 1'b0;
            full_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r    <= term_s;
            wrapped_r <= term_s & at_end_s & WRAP_BIT;
            err_r     <= err_r | (nextByte & full_r);
            if (term_s) begin
                addr_r <= addr_nxt_s;
                cnt_r  <= cnt_sat_s;
                full_r <= at_end_s & ~WRAP_BIT;
            end else begin
                addr_r <= addr_r;
                cnt_r  <= cnt_r;
                full_r <= full_r;
            end
        end
    end

    assign addr        = addr_r;
    assign byteIdx     = byte_idx_s;
    assign blockCount  = cnt_r;
    assign blockDone   = done_r;
    assign wrapped     = wrapped_r;
    assign full        = full_r;
    assign errOverflow = err_r;

endmodule

// File: tb/tb_sdc_block_addr_gen.sv
// Directed bench for sdc_block_addr_gen: a vector table on the default block-mode
// instance plus hand-written sequences on byte-mode, wrap, stop and saturation variants.
module tb_sdc_block_addr_gen;

    logic        clk = 1'b0;
    logic        rst_s = 1'b0;
    logic        ld_s = 1'b0;
    logic [31:0] lv_s = 32'd0;
    logic        nb_s = 1'b0;

    int total = 0;
    int bad = 0;
    int bad_addr = 0;
    int dones = 0;

    always #5 clk = ~clk;

    logic [31:0] a_blk, a_byt, a_wrp, a_stp, a_sat;
    logic [8:0]  i_blk, i_byt, i_wrp, i_stp;
    logic [1:0]  i_sat;
    logic [15:0] c_blk, c_byt, c_wrp, c_stp;
    logic [1:0]  c_sat;
    logic        d_blk, d_byt, d_wrp, d_stp, d_sat;
    logic        w_blk, w_byt, w_wrp, w_stp, w_sat;
    logic        f_blk, f_byt, f_wrp, f_stp, f_sat;
    logic        e_blk, e_byt, e_wrp, e_stp, e_sat;

    sdc_block_addr_gen u_blk (
        .clk(clk), .resetCounter(rst_s), .loadAddr(ld_s), .loadValue(lv_s), .nextByte(nb_s),
        .addr(a_blk), .byteIdx(i_blk), .blockCount(c_blk), .blockDone(d_blk),
        .wrapped(w_blk), .full(f_blk), .errOverflow(e_blk));

    sdc_block_addr_gen #(.ADDR_MODE(0)) u_byt (
        .clk(clk), .resetCounter(rst_s), .loadAddr(ld_s), .loadValue(lv_s), .nextByte(nb_s),
        .addr(a_byt), .byteIdx(i_byt), .blockCount(c_byt), .blockDone(d_byt),
        .wrapped(w_byt), .full(f_byt), .errOverflow(e_byt));

    sdc_block_addr_gen #(.END_ADDR(32'd3), .WRAP_EN(1)) u_wrp (
        .clk(clk), .resetCounter(rst_s), .loadAddr(ld_s), .loadValue(lv_s), .nextByte(nb_s),
        .addr(a_wrp), .byteIdx(i_wrp), .blockCount(c_wrp), .blockDone(d_wrp),
        .wrapped(w_wrp), .full(f_wrp), .errOverflow(e_wrp));

    sdc_block_addr_gen #(.END_ADDR(32'd1), .WRAP_EN(0)) u_stp (
        .clk(clk), .resetCounter(rst_s), .loadAddr(ld_s), .loadValue(lv_s), .nextByte(nb_s),
        .addr(a_stp), .byteIdx(i_stp), .blockCount(c_stp), .blockDone(d_stp),
        .wrapped(w_stp), .full(f_stp), .errOverflow(e_stp));

    sdc_block_addr_gen #(.BLOCK_BYTES(4), .CNT_W(2)) u_sat (
        .clk(clk), .resetCounter(rst_s), .loadAddr(ld_s), .loadValue(lv_s), .nextByte(nb_s),
        .addr(a_sat), .byteIdx(i_sat), .blockCount(c_sat), .blockDone(d_sat),
        .wrapped(w_sat), .full(f_sat), .errOverflow(e_sat));

    typedef struct {
        logic        rst;
        logic        ld;
        logic [31:0] lv;
        logic        nb;
        int          reps;
        logic [31:0] e_addr;
        logic [8:0]  e_idx;
        logic [15:0] e_cnt;
        logic        e_done;
        logic        e_full;
        logic        e_err;
    } vec_t;

    vec_t vt[$];
    logic [31:0] exp_w [4];

    task automatic tick(input logic r, input logic l, input logic [31:0] v, input logic n);
        rst_s = r;
        ld_s  = l;
        lv_s  = v;
        nb_s  = n;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        //                 rst   ld    lv             nb   reps  addr           idx     cnt     done  full  err
        vt.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1,   32'h0,         9'd0,   16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1,   32'h0,         9'd1,   16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 510, 32'h0,         9'd511, 16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1,   32'h1,         9'd0,   16'd1,  1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1,   32'h1,         9'd0,   16'd1,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 32'h0000_FFFF, 1'b0, 1,   32'h0000_FFFF, 9'd0,   16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 512, 32'h0001_0000, 9'd0,   16'd1,  1'b1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 511, 32'h0001_0000, 9'd511, 16'd1,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 32'h20,        1'b1, 1,   32'h20,        9'd0,   16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1,   32'h20,        9'd0,   16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 200, 32'h20,        9'd200, 16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1,   32'h0,         9'd0,   16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1,   32'hFFFF_FFFF, 9'd0,   16'd0,  1'b0, 1'b0, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 512, 32'hFFFF_FFFF, 9'd0,   16'd1,  1'b1, 1'b1, 1'b0});
        vt.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 5,   32'hFFFF_FFFF, 9'd0,   16'd1,  1'b0, 1'b1, 1'b1});
        vt.push_back('{1'b0, 1'b1, 32'h5,         1'b0, 1,   32'h5,         9'd0,   16'd0,  1'b0, 1'b0, 1'b0});

        @(negedge clk);
        foreach (vt[k]) begin
            for (int r = 0; r < vt[k].reps; r++) begin
                tick(vt[k].rst, vt[k].ld, vt[k].lv, vt[k].nb);
            end
            chk($sformatf("v%0d.addr", k), 64'(a_blk), 64'(vt[k].e_addr));
            chk($sformatf("v%0d.idx", k),  64'(i_blk), 64'(vt[k].e_idx));
            chk($sformatf("v%0d.cnt", k),  64'(c_blk), 64'(vt[k].e_cnt));
            chk($sformatf("v%0d.done", k), 64'(d_blk), 64'(vt[k].e_done));
            chk($sformatf("v%0d.full", k), 64'(f_blk), 64'(vt[k].e_full));
            chk($sformatf("v%0d.err", k),  64'(e_blk), 64'(vt[k].e_err));
            chk($sformatf("v%0d.wrap", k), 64'(w_blk), 64'd0);
        end

        // Byte addressing across a 16-bit carry boundary.
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b1, 32'h0000_FE00, 1'b0);
        chk("t2.load", 64'(a_byt), 64'h0000_FE00);
        bad_addr = 0;
        dones = 0;
        for (int s = 1; s <= 512; s++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (s < 512 && a_byt !== 32'h0000_FE00) bad_addr++;
            if (d_byt) dones++;
        end
        chk("t2.addr", 64'(a_byt), 64'h0001_0000);
        chk("t2.done_last", 64'(d_byt), 64'd1);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        if (d_byt) dones++;
        chk("t2.done_count", 64'(dones), 64'd1);
        chk("t2.early_addr", 64'(bad_addr), 64'd0);
        chk("t2.cnt", 64'(c_byt), 64'd1);

        // Wrap at END_ADDR=3.
        exp_w = '{32'd1, 32'd2, 32'd3, 32'd0};
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            repeat (511) tick(1'b0, 1'b0, 32'h0, 1'b1);
            chk($sformatf("t3.b%0d.pre_done", b), 64'(d_wrp), 64'd0);
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            chk($sformatf("t3.b%0d.addr", b), 64'(a_wrp), 64'(exp_w[b]));
            chk($sformatf("t3.b%0d.wrapped", b), 64'(w_wrp), (b == 3) ? 64'd1 : 64'd0);
            chk($sformatf("t3.b%0d.done", b), 64'(d_wrp), 64'd1);
            tick(1'b0, 1'b0, 32'h0, 1'b0);
            chk($sformatf("t3.b%0d.wrap_clear", b), 64'(w_wrp), 64'd0);
        end
        chk("t3.cnt", 64'(c_wrp), 64'd4);
        chk("t3.full", 64'(f_wrp), 64'd0);

        // Stop at END_ADDR=1, overflow, then recover by load.
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (1024) tick(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4.full", 64'(f_stp), 64'd1);
        chk("t4.addr", 64'(a_stp), 64'd1);
        chk("t4.cnt", 64'(c_stp), 64'd2);
        chk("t4.err_before", 64'(e_stp), 64'd0);
        repeat (5) tick(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4.idx_hold", 64'(i_stp), 64'd0);
        chk("t4.err", 64'(e_stp), 64'd1);
        chk("t4.cnt_hold", 64'(c_stp), 64'd2);
        chk("t4.addr_hold", 64'(a_stp), 64'd1);
        tick(1'b0, 1'b1, 32'h10, 1'b0);
        chk("t4.full_clr", 64'(f_stp), 64'd0);
        chk("t4.err_clr", 64'(e_stp), 64'd0);
        chk("t4.addr_load", 64'(a_stp), 64'h10);

        // Block counter saturation on a 4-byte-block, 2-bit-count variant.
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (20) tick(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t7.cnt_sat", 64'(c_sat), 64'd3);
        chk("t7.addr", 64'(a_sat), 64'd5);
        chk("t7.idx", 64'(i_sat), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
